perfect_range_scanner: RTL and testbench

Upstream/downstream driver for the perfect-number checker. Sweeps an inclusive range of candidates [lo, hi] and issues one go/done handshake per candidate to the checker. Counts the perfect results and buffers each perfect candidate in a small FIFO for a consumer. Sits between the host/test logic and the checker's x/go/display/finish pins.

---
 rtl/perfect_range_scanner_pkg.sv | 19 +
 rtl/perfect_range_scanner_if.sv | 13 +
 rtl/perfect_range_scanner_scan_result_fifo.sv | 59 +++++
 rtl/perfect_range_scanner.sv | 175 +++++++++++++++++
 tb/tb_perfect_range_scanner.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perfect_range_scanner_pkg.sv
// Shared types and widths for the perfect-number range scanner and its result FIFO.
package perfect_pkg;

  localparam int W  = 16;
  localparam int CW = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE,
    FIN
  } state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

endpackage

// File: rtl/perfect_range_scanner_if.sv
// Go/done handshake bus between the scanner (master) and the perfect-number checker (slave).
interface perfect_range_scanner_if;
  import perfect_pkg::*;

  logic [W-1:0] chk_x;
  logic         chk_go;
  logic         chk_done;
  logic         chk_perfect;

  modport master (output chk_x, output chk_go, input chk_done, input chk_perfect);
  modport slave  (input chk_x, input chk_go, output chk_done, output chk_perfect);

endinterface

// File: rtl/perfect_range_scanner_scan_result_fifo.sv
// Synchronous result FIFO; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module scan_result_fifo
  import perfect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_pop;
  logic         do_push;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    head    = mem_q[rd_q[AW-1:0]];
    do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/perfect_range_scanner.sv
// Sweeps candidates lo..hi through the perfect-number checker, counting hits and queueing them.
module perfect_range_scanner
  import perfect_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [W-1:0]            lo,
  input  logic [W-1:0]            hi,
  output logic                    busy,
  output logic                    done,
  output logic                    range_err,
  output logic                    timeout,
  output logic                    overflow,
  output logic [CW-1:0]           count,
  perfect_range_scanner_if.master chk,
  output logic                    res_valid,
  output logic [W-1:0]            res_data,
  input  logic                    res_ready
);

  localparam int TW = $clog2(TIMEOUT);

  state_e        state_q, state_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          range_err_q, range_err_d;
  logic          timeout_q, timeout_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  chk_x_q, chk_x_d;
  logic          chk_go_q, chk_go_d;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    hi_d        = hi_q;
    wcnt_d      = wcnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    range_err_d = range_err_q;
    timeout_d   = timeout_q;
    overflow_d  = overflow_q;
    count_d     = count_q;
    chk_x_d     = chk_x_q;
    chk_go_d    = chk_go_q;
    push        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          range_err_d = 1'b0;
          timeout_d   = 1'b0;
          overflow_d  = 1'b0;
          count_d     = '0;
          hi_d        = hi;
          cur_d       = lo;
          if (lo == '0 || lo > hi) begin
            range_err_d = 1'b1;
            state_d     = FIN;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        chk_x_d  = cur_q;
        chk_go_d = 1'b1;
        wcnt_d   = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (chk.chk_done) begin
          chk_go_d = 1'b0;
          if (chk.chk_perfect) begin
            count_d = sat_inc(count_q);
            push    = 1'b1;
          end
          state_d = RELEASE;
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          chk_go_d  = 1'b0;
          state_d   = FIN;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      RELEASE: begin
        // Compare before increment so hi = all-ones terminates without wrapping.
        if (!chk.chk_done) begin
          if (cur_q == hi_q) begin
            state_d = FIN;
          end else begin
            cur_d   = cur_q + W'(1);
            state_d = ISSUE;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fifo_drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      hi_q        <= '0;
      wcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      chk_x_q     <= '0;
      chk_go_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      hi_q        <= hi_d;
      wcnt_q      <= wcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      range_err_q <= range_err_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      chk_x_q     <= chk_x_d;
      chk_go_q    <= chk_go_d;
    end
  end

  scan_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_data (cur_q),
    .pop       (res_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (res_data),
    .drop      (fifo_drop)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign range_err  = range_err_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;
  assign count      = count_q;
  assign chk.chk_x  = chk_x_q;
  assign chk.chk_go = chk_go_q;
  assign res_valid  = !fifo_empty;

endmodule

// File: tb/tb_perfect_range_scanner.sv
// Directed bench for perfect_range_scanner with a behavioural checker model and a never-done checker.
module tb_perfect_range_scanner;
  import perfect_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [15:0] lo = '0, hi = '0;
  logic        res_ready = 1'b0;
  logic        busy, done, range_err, timeout, overflow, res_valid;
  logic [7:0]  count;
  logic [15:0] res_data;

  logic        start_to = 1'b0;
  logic [15:0] lo_to = '0, hi_to = '0;
  logic        res_ready_to = 1'b0;
  logic        busy_to, done_to, range_err_to, timeout_to, overflow_to, res_valid_to;
  logic [7:0]  count_to;
  logic [15:0] res_data_to;

  int checks = 0;
  int failures = 0;
  int model_mode = 0;
  int done_cnt = 0;
  int go_rise = 0;
  logic go_prev = 1'b0;
  logic [15:0] pop_q[$];

  perfect_range_scanner_if bus();
  perfect_range_scanner_if bus_to();

  always #5 clk = ~clk;

  perfect_range_scanner #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .clr(clr), .start(start), .lo(lo), .hi(hi),
    .busy(busy), .done(done), .range_err(range_err), .timeout(timeout),
    .overflow(overflow), .count(count), .chk(bus),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  perfect_range_scanner #(.DEPTH(4), .TIMEOUT(16)) dut_to (
    .clk(clk), .clr(clr), .start(start_to), .lo(lo_to), .hi(hi_to),
    .busy(busy_to), .done(done_to), .range_err(range_err_to), .timeout(timeout_to),
    .overflow(overflow_to), .count(count_to), .chk(bus_to),
    .res_valid(res_valid_to), .res_data(res_data_to), .res_ready(res_ready_to)
  );

  function automatic bit is_perfect(input int x);
    int s = 0;
    if (x < 2) return 1'b0;
    for (int d = 1; d < x; d++) if (x % d == 0) s += d;
    return s == x;
  endfunction

  // Checker model: verdict 20 cycles after go, done held until go falls.
  initial begin
    int lat = 0;
    bus.chk_done = 1'b0;
    bus.chk_perfect = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!bus.chk_go) begin
        bus.chk_done = 1'b0;
        bus.chk_perfect = 1'b0;
        lat = 0;
      end else if (!bus.chk_done) begin
        lat++;
        if (lat >= 20) begin
          bus.chk_done = 1'b1;
          bus.chk_perfect = (model_mode == 1) ? 1'b1 : is_perfect(int'(bus.chk_x));
        end
      end
    end
  end

  initial begin
    bus_to.chk_done = 1'b0;
    bus_to.chk_perfect = 1'b0;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.chk_go && !go_prev) go_rise++;
    go_prev = bus.chk_go;
    if (res_valid && res_ready) pop_q.push_back(res_data);
  end

  task automatic pulse_start(input logic [15:0] l, input logic [15:0] h);
    @(negedge clk);
    lo = l; hi = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    seen = done;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    res_ready = v;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, range_err, timeout, overflow} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, range_err, timeout, overflow});
    end
    checks++;
    if ({count, bus.chk_go, bus.chk_x} !== 25'd0) begin
      failures++;
      $display("FAIL reset_count_chk: count=%0d go=%b x=%0d want 0", count, bus.chk_go, bus.chk_x);
    end
    checks++;
    if ({res_valid, res_data} !== 17'd0) begin
      failures++;
      $display("FAIL reset_fifo: valid=%b data=%0d want 0", res_valid, res_data);
    end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep_1_30();
    bit seen;
    model_mode = 0;
    set_ready(1'b1);
    pop_q.delete();
    done_cnt = 0;
    pulse_start(16'd1, 16'd30);
    wait_done(2000, seen);
    @(negedge clk);
    checks++;
    if (!seen) begin failures++; $display("FAIL sweep_done: done not seen within budget"); end
    checks++;
    if (count !== 8'd2) begin failures++; $display("FAIL sweep_count: got %0d want 2", count); end
    checks++;
    if (pop_q.size() != 2) begin
      failures++; $display("FAIL sweep_pops: got %0d results want 2", pop_q.size());
    end else if (pop_q[0] !== 16'd6 || pop_q[1] !== 16'd28) begin
      failures++; $display("FAIL sweep_pops: got %0d,%0d want 6,28", pop_q[0], pop_q[1]);
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL sweep_done_once: got %0d pulses want 1", done_cnt); end
    checks++;
    if ({busy, range_err, timeout, overflow} !== 4'b0) begin
      failures++; $display("FAIL sweep_flags: got %b want 0000", {busy, range_err, timeout, overflow});
    end
    set_ready(1'b0);
  endtask

  task automatic test_single_28();
    bit seen;
    go_rise = 0;
    pulse_start(16'd28, 16'd28);
    wait_done(200, seen);
    @(negedge clk);
    checks++;
    if (!seen || count !== 8'd1) begin
      failures++; $display("FAIL single_count: done=%b count=%0d want done count=1", seen, count);
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'd28) begin
      failures++; $display("FAIL single_head: valid=%b data=%0d want 1,28", res_valid, res_data);
    end
    checks++;
    if (go_rise != 1) begin failures++; $display("FAIL single_go_pulses: got %0d want 1", go_rise); end
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL single_pop: valid=%b want 0", res_valid); end
  endtask

  task automatic test_range_err();
    go_rise = 0;
    pulse_start(16'd10, 16'd5);
    checks++;
    if (range_err !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL rerr_edge0: err=%b done=%b busy=%b want 1,0,1", range_err, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rerr_edge1: done=%b busy=%b want 1,0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || count !== 8'd0 || go_rise != 0 || bus.chk_go !== 1'b0) begin
      failures++;
      $display("FAIL rerr_after: done=%b count=%0d go_pulses=%0d want 0,0,0", done, count, go_rise);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    model_mode = 1;
    pop_q.delete();
    pulse_start(16'd1, 16'd6);
    wait_done(300, seen);
    @(negedge clk);
    checks++;
    if (!seen || count !== 8'd6) begin
      failures++; $display("FAIL ovf_count: done=%b count=%0d want 6", seen, count);
    end
    checks++;
    if (overflow !== 1'b1 || res_valid !== 1'b1) begin
      failures++; $display("FAIL ovf_flag: overflow=%b valid=%b want 1,1", overflow, res_valid);
    end
    set_ready(1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (pop_q.size() != 4) begin
      failures++; $display("FAIL ovf_pops: got %0d results want 4", pop_q.size());
    end else if (pop_q[0] !== 16'd1 || pop_q[1] !== 16'd2 || pop_q[2] !== 16'd3 || pop_q[3] !== 16'd4) begin
      failures++;
      $display("FAIL ovf_pops: got %0d,%0d,%0d,%0d want 1,2,3,4", pop_q[0], pop_q[1], pop_q[2], pop_q[3]);
    end
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty: valid=%b want 0", res_valid); end
    set_ready(1'b0);
    model_mode = 0;
  endtask

  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    lo_to = 16'd3; hi_to = 16'd9; start_to = 1'b1;
    @(negedge clk);
    start_to = 1'b0;
    while (!bus_to.chk_go && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (bus_to.chk_go && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != 16) begin failures++; $display("FAIL to_go_width: go high %0d cycles want 16", n); end
    @(negedge clk);
    checks++;
    if (done_to !== 1'b1 || timeout_to !== 1'b1 || count_to !== 8'd0) begin
      failures++;
      $display("FAIL to_flags: done=%b timeout=%b count=%0d want 1,1,0", done_to, timeout_to, count_to);
    end
    @(negedge clk);
    checks++;
    if (done_to !== 1'b0 || busy_to !== 1'b0) begin
      failures++; $display("FAIL to_after: done=%b busy=%b want 0,0", done_to, busy_to);
    end
  endtask

  task automatic test_clr_mid_sweep();
    bit seen;
    int n = 0;
    pulse_start(16'd1, 16'd30);
    while (count !== 8'd1 && n < 400) begin @(negedge clk); n++; end
    n = 0;
    while (!bus.chk_go && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || bus.chk_go !== 1'b1 || count !== 8'd1) begin
      failures++;
      $display("FAIL clr_pre: valid=%b go=%b count=%0d want 1,1,1", res_valid, bus.chk_go, count);
    end
    clr = 1'b1;
    #1;
    checks++;
    if ({busy, done, range_err, timeout, overflow, count, bus.chk_go, bus.chk_x, res_valid, res_data} !== 47'd0) begin
      failures++;
      $display("FAIL clr_async: busy=%b go=%b x=%0d count=%0d valid=%b data=%0d want all 0",
               busy, bus.chk_go, bus.chk_x, count, res_valid, res_data);
    end
    @(negedge clk);
    clr = 1'b0;
    pulse_start(16'd6, 16'd6);
    wait_done(200, seen);
    @(negedge clk);
    checks++;
    if (!seen || count !== 8'd1 || res_data !== 16'd6 || res_valid !== 1'b1) begin
      failures++;
      $display("FAIL clr_restart: done=%b count=%0d data=%0d valid=%b want 1,1,6,1", seen, count, res_data, res_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_1_30();
    test_single_28();
    test_range_err();
    test_overflow();
    test_timeout();
    test_clr_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
